id_r_queue: RTL and testbench
=============================

# id_r_queue

Registered, parametrised R-type decode stage with a small output queue. Accepts raw 32-bit instruction words plus PC over a valid/ready handshake, decodes SPECIAL (and optionally SPECIAL2) opcodes into internal `INST_*` codes and register fields, and buffers up to DEPTH decoded entries for the issue logic. It sits between fetch and the issue/operand-read stage and decouples decode from issue stalls.

## Interface
- INST_W, 8, width of internal instruction code; must match `INST_*` width in defs.v
- PC_W, 32, width of PC passthrough
- DEPTH, 2, queue entries; power of two, 2..8
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous queue clear (branch mispredict/exception)
- in_valid  in  1  instruction word present
- in_ready  out  1  queue can accept this cycle
- in_code  in  32  raw instruction word
- in_pc  in  PC_W  PC of in_code
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head this cycle
- out_inst  out  INST_W  decoded code, `INST_INVALID` if not a supported R-type
- out_reg_s / out_reg_t / out_reg_d / out_shift  out  5 each  fields [25:21]/[20:16]/[15:11]/[10:6]
- out_wr_reg  out  5  destination GPR written, 0 if none
- out_invalid  out  1  1 when out_inst is `INST_INVALID` (reserved-instruction trigger)
- out_pc  out  PC_W  PC of head entry

## Operation
- Decode is combinational on in_code, result stored in queue at push; out_* driven from head storage registers.
- SPECIAL (opcode 000000), funct: 00 SLL, 02 SRL, 03 SRA, 04 SLLV, 06 SRLV, 07 SRAV, 08 JR, 09 JALR, 0a MOVZ, 0b MOVN, 0c SYSCALL, 0d BREAK, 10 MFHI, 11 MTHI, 12 MFLO, 13 MTLO, 18 MULT, 19 MULTU, 1a DIV, 1b DIVU, 20 ADD, 21 ADDU, 22 SUB, 23 SUBU, 24 AND, 25 OR, 26 XOR, 27 NOR, 2a SLT, 2b SLTU; other funct -> INVALID.
- SPECIAL2 (opcode 011100), funct: 00 MADD, 01 MADDU, 02 MUL, 04 MSUB, 05 MSUBU, 20 CLZ, 21 CLO; other -> INVALID. Gated by macro (see Configuration).
- Any other opcode -> INVALID, out_wr_reg = 0.
- out_wr_reg = rd for shifts, ALU ops, MOVZ/MOVN, MFHI/MFLO, JALR, MUL, CLZ/CLO; 0 for JR, SYSCALL, BREAK, MTHI/MTLO, MULT*/DIV*, MADD*/MSUB*, INVALID. rd = 0 yields 0 naturally.
- Queue: circular buffer, rd/wr pointers log2(DEPTH) bits wrapping modulo DEPTH, count 0..DEPTH.
- Push when in_valid && in_ready; pop when out_valid && out_ready; both in one cycle -> count unchanged, both pointers advance.
- in_ready = (count < DEPTH); no combinational dependence on out_ready.
- out_valid = (count != 0).
- flush: pointers and count to 0 next cycle; a push in the flush cycle is discarded; flush has priority over push and pop.

## Timing
- Reset (rst=1 at edge): count 0, pointers 0, out_valid 0, in_ready 1 next cycle; all out_* data outputs 0 (storage cleared).
- Latency: word accepted at edge N is on out_* with out_valid=1 after edge N (cycle N+1) when queue was empty.
- Throughput: 1 entry/cycle sustained when out_ready held high.
- Full: in_ready=0 from cycle after count reaches DEPTH; in_valid while full is ignored, source must hold data.
- Head data stable while out_valid && !out_ready.
- rst mid-operation: all entries discarded, same as reset state; rst overrides flush.

## Configuration
- ID_SPECIAL2_EN defined: SPECIAL2 decoded as listed.
- Not defined: all SPECIAL2 words decode INVALID, out_invalid=1, out_wr_reg=0; SPECIAL2 decode logic absent.

## Test plan
- Reset then push 0x012A4020 (ADD $8,$9,$10), pc 0x100 -> next cycle out_valid=1, out_inst=`INST_ADD`, reg_s 9, reg_t 10, reg_d 8, out_wr_reg 8, out_pc 0x100.
- Push 0x01200008 (JR $9) and 0x00000022 -> JR with out_wr_reg 0; funct 0x22 -> `INST_SUB`, distinct from ADDU on 0x21.
- out_ready=0, push DEPTH words -> in_ready drops after DEPTH accepts; extra word ignored; release out_ready -> entries exit in order, PCs intact across pointer wrap.
- Simultaneous push/pop at count=1 for 10 cycles -> count stays 1, output stream matches input order with 1-cycle lag.
- 0x71095002 (MUL $10,$8,$9) -> with ID_SPECIAL2_EN `INST_MUL`, wr_reg 10; without it INVALID, out_invalid=1, wr_reg 0. Opcode 0x08 word -> INVALID either way.
- Queue holding 2 entries, assert flush with in_valid=1 -> next cycle out_valid=0, count 0, flushed-cycle word not present.

Source files
------------

// File: rtl/id_r_queue_if.sv
// Handshake bundle between fetch, the R-type decode queue and issue.
// slave is the queue's view; master is the fetch/issue side.
interface id_r_queue_if #(
  parameter int INST_W = 8,
  parameter int PC_W   = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_code;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [4:0]        out_reg_s;
  logic [4:0]        out_reg_t;
  logic [4:0]        out_reg_d;
  logic [4:0]        out_shift;
  logic [4:0]        out_wr_reg;
  logic              out_invalid;
  logic [PC_W-1:0]   out_pc;

  modport master (
    output in_valid, in_code, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_reg_s, out_reg_t, out_reg_d,
           out_shift, out_wr_reg, out_invalid, out_pc
  );

  modport slave (
    input  in_valid, in_code, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_reg_s, out_reg_t, out_reg_d,
           out_shift, out_wr_reg, out_invalid, out_pc
  );
endinterface

// File: rtl/id_r_queue.sv
// R-type decode stage with a DEPTH-entry circular output queue.
// Define ID_SPECIAL2_EN to decode SPECIAL2 (MADD/MUL/CLZ...); otherwise those words are INVALID.

`ifndef INST_INVALID
`define INST_INVALID 8'd0
`define INST_SLL     8'd1
`define INST_SRL     8'd2
`define INST_SRA     8'd3
`define INST_SLLV    8'd4
`define INST_SRLV    8'd5
`define INST_SRAV    8'd6
`define INST_JR      8'd7
`define INST_JALR    8'd8
`define INST_MOVZ    8'd9
`define INST_MOVN    8'd10
`define INST_SYSCALL 8'd11
`define INST_BREAK   8'd12
`define INST_MFHI    8'd13
`define INST_MTHI    8'd14
`define INST_MFLO    8'd15
`define INST_MTLO    8'd16
`define INST_MULT    8'd17
`define INST_MULTU   8'd18
`define INST_DIV     8'd19
`define INST_DIVU    8'd20
`define INST_ADD     8'd21
`define INST_ADDU    8'd22
`define INST_SUB     8'd23
`define INST_SUBU    8'd24
`define INST_AND     8'd25
`define INST_OR      8'd26
`define INST_XOR     8'd27
`define INST_NOR     8'd28
`define INST_SLT     8'd29
`define INST_SLTU    8'd30
`define INST_MADD    8'd31
`define INST_MADDU   8'd32
`define INST_MUL     8'd33
`define INST_MSUB    8'd34
`define INST_MSUBU   8'd35
`define INST_CLZ     8'd36
`define INST_CLO     8'd37
`endif

module id_r_queue #(
  parameter int INST_W = 8,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  id_r_queue_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rd;
  logic [7:0] dec_code;
  logic       dec_wr;

  assign opcode = bus.in_code[31:26];
  assign funct  = bus.in_code[5:0];
  assign rd     = bus.in_code[15:11];

  // dec_wr marks opcodes whose result lands in rd; everything else writes no GPR
  always_comb begin
    dec_code = `INST_INVALID;
    dec_wr   = 1'b0;
    if (opcode == 6'b000000) begin
      case (funct)
        6'h00: begin dec_code = `INST_SLL;     dec_wr = 1'b1; end
        6'h02: begin dec_code = `INST_SRL;     dec_wr = 1'b1; end
        6'h03: begin dec_code = `INST_SRA;     dec_wr = 1'b1; end
        6'h04: begin dec_code = `INST_SLLV;    dec_wr = 1'b1; end
        6'h06: begin dec_code = `INST_SRLV;    dec_wr = 1'b1; end
        6'h07: begin dec_code = `INST_SRAV;    dec_wr = 1'b1; end
        6'h08: begin dec_code = `INST_JR;      dec_wr = 1'b0; end
        6'h09: begin dec_code = `INST_JALR;    dec_wr = 1'b1; end
        6'h0a: begin dec_code = `INST_MOVZ;    dec_wr = 1'b1; end
        6'h0b: begin dec_code = `INST_MOVN;    dec_wr = 1'b1; end
        6'h0c: begin dec_code = `INST_SYSCALL; dec_wr = 1'b0; end
        6'h0d: begin dec_code = `INST_BREAK;   dec_wr = 1'b0; end
        6'h10: begin dec_code = `INST_MFHI;    dec_wr = 1'b1; end
        6'h11: begin dec_code = `INST_MTHI;    dec_wr = 1'b0; end
        6'h12: begin dec_code = `INST_MFLO;    dec_wr = 1'b1; end
        6'h13: begin dec_code = `INST_MTLO;    dec_wr = 1'b0; end
        6'h18: begin dec_code = `INST_MULT;    dec_wr = 1'b0; end
        6'h19: begin dec_code = `INST_MULTU;   dec_wr = 1'b0; end
        6'h1a: begin dec_code = `INST_DIV;     dec_wr = 1'b0; end
        6'h1b: begin dec_code = `INST_DIVU;    dec_wr = 1'b0; end
        6'h20: begin dec_code = `INST_ADD;     dec_wr = 1'b1; end
        6'h21: begin dec_code = `INST_ADDU;    dec_wr = 1'b1; end
        6'h22: begin dec_code = `INST_SUB;     dec_wr = 1'b1; end
        6'h23: begin dec_code = `INST_SUBU;    dec_wr = 1'b1; end
        6'h24: begin dec_code = `INST_AND;     dec_wr = 1'b1; end
        6'h25: begin dec_code = `INST_OR;      dec_wr = 1'b1; end
        6'h26: begin dec_code = `INST_XOR;     dec_wr = 1'b1; end
        6'h27: begin dec_code = `INST_NOR;     dec_wr = 1'b1; end
        6'h2a: begin dec_code = `INST_SLT;     dec_wr = 1'b1; end
        6'h2b: begin dec_code = `INST_SLTU;    dec_wr = 1'b1; end
        default: begin dec_code = `INST_INVALID; dec_wr = 1'b0; end
      endcase
    end
`ifdef ID_SPECIAL2_EN
    else if (opcode == 6'b011100) begin
      case (funct)
        6'h00: begin dec_code = `INST_MADD;  dec_wr = 1'b0; end
        6'h01: begin dec_code = `INST_MADDU; dec_wr = 1'b0; end
        6'h02: begin dec_code = `INST_MUL;   dec_wr = 1'b1; end
        6'h04: begin dec_code = `INST_MSUB;  dec_wr = 1'b0; end
        6'h05: begin dec_code = `INST_MSUBU; dec_wr = 1'b0; end
        6'h20: begin dec_code = `INST_CLZ;   dec_wr = 1'b1; end
        6'h21: begin dec_code = `INST_CLO;   dec_wr = 1'b1; end
        default: begin dec_code = `INST_INVALID; dec_wr = 1'b0; end
      endcase
    end
`endif
  end

  logic [INST_W-1:0] dec_inst;
  logic [4:0]        dec_wr_reg;
  logic              dec_invalid;

  assign dec_inst    = INST_W'(dec_code);
  assign dec_wr_reg  = dec_wr ? rd : 5'd0;
  assign dec_invalid = (dec_code == `INST_INVALID);

  logic [INST_W-1:0] mem_inst    [DEPTH];
  logic [4:0]        mem_reg_s   [DEPTH];
  logic [4:0]        mem_reg_t   [DEPTH];
  logic [4:0]        mem_reg_d   [DEPTH];
  logic [4:0]        mem_shift   [DEPTH];
  logic [4:0]        mem_wr_reg  [DEPTH];
  logic              mem_invalid [DEPTH];
  logic [PC_W-1:0]   mem_pc      [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  assign bus.in_ready  = (count < DEPTH_C);
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // Storage is cleared on reset so out_* read zero until the first push
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i]    <= '0;
        mem_reg_s[i]   <= '0;
        mem_reg_t[i]   <= '0;
        mem_reg_d[i]   <= '0;
        mem_shift[i]   <= '0;
        mem_wr_reg[i]  <= '0;
        mem_invalid[i] <= 1'b0;
        mem_pc[i]      <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_inst[wr_ptr]    <= dec_inst;
        mem_reg_s[wr_ptr]   <= bus.in_code[25:21];
        mem_reg_t[wr_ptr]   <= bus.in_code[20:16];
        mem_reg_d[wr_ptr]   <= bus.in_code[15:11];
        mem_shift[wr_ptr]   <= bus.in_code[10:6];
        mem_wr_reg[wr_ptr]  <= dec_wr_reg;
        mem_invalid[wr_ptr] <= dec_invalid;
        mem_pc[wr_ptr]      <= bus.in_pc;
        wr_ptr              <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.out_inst    = mem_inst[rd_ptr];
  assign bus.out_reg_s   = mem_reg_s[rd_ptr];
  assign bus.out_reg_t   = mem_reg_t[rd_ptr];
  assign bus.out_reg_d   = mem_reg_d[rd_ptr];
  assign bus.out_shift   = mem_shift[rd_ptr];
  assign bus.out_wr_reg  = mem_wr_reg[rd_ptr];
  assign bus.out_invalid = mem_invalid[rd_ptr];
  assign bus.out_pc      = mem_pc[rd_ptr];

endmodule

// File: tb/tb_id_r_queue.sv
// Directed bench for id_r_queue: decode table, queue fill/drain, streaming, flush and reset.
module tb_id_r_queue;

  localparam logic [7:0] E_INVALID = 8'd0;
  localparam logic [7:0] E_SLL     = 8'd1;
  localparam logic [7:0] E_JR      = 8'd7;
  localparam logic [7:0] E_JALR    = 8'd8;
  localparam logic [7:0] E_MFLO    = 8'd15;
  localparam logic [7:0] E_MULT    = 8'd17;
  localparam logic [7:0] E_ADD     = 8'd21;
  localparam logic [7:0] E_ADDU    = 8'd22;
  localparam logic [7:0] E_SUB     = 8'd23;
  localparam logic [7:0] E_MUL     = 8'd33;
  localparam logic [7:0] E_CLZ     = 8'd36;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  id_r_queue_if #(.INST_W(8), .PC_W(32)) bus ();

  id_r_queue #(.INST_W(8), .PC_W(32), .DEPTH(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_code = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
    checks++; if (bus.out_inst !== 8'd0 || bus.out_pc !== 32'd0 || bus.out_wr_reg !== 5'd0 || bus.out_invalid !== 1'b0)
      begin errors++; $display("FAIL reset_data: inst %0h pc %0h wr %0d inv %0b want all 0", bus.out_inst, bus.out_pc, bus.out_wr_reg, bus.out_invalid); end
  endtask

  task automatic test_add();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_code = 32'h012A4020; bus.in_pc = 32'h100;
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %0b want 1", bus.out_valid); end
    checks++; if (bus.out_inst !== E_ADD) begin errors++; $display("FAIL add_inst: got %0d want %0d", bus.out_inst, E_ADD); end
    checks++; if (bus.out_reg_s !== 5'd9 || bus.out_reg_t !== 5'd10 || bus.out_reg_d !== 5'd8)
      begin errors++; $display("FAIL add_regs: got s%0d t%0d d%0d want s9 t10 d8", bus.out_reg_s, bus.out_reg_t, bus.out_reg_d); end
    checks++; if (bus.out_wr_reg !== 5'd8) begin errors++; $display("FAIL add_wr_reg: got %0d want 8", bus.out_wr_reg); end
    checks++; if (bus.out_pc !== 32'h100) begin errors++; $display("FAIL add_pc: got %0h want 100", bus.out_pc); end
    checks++; if (bus.out_invalid !== 1'b0) begin errors++; $display("FAIL add_invalid: got %0b want 0", bus.out_invalid); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_decode();
    logic [31:0] codes [11] = '{32'h01200008, 32'h00000022, 32'h00000021, 32'h0120F809,
                                32'h00004012, 32'h01090018, 32'h0000003F, 32'h00095080,
                                32'h21095000, 32'h71095002, 32'h71095020};
    logic [7:0]  e_inst [11];
    logic [4:0]  e_wr [11];
    logic        e_inv [11];
`ifdef ID_SPECIAL2_EN
    e_inst = '{E_JR, E_SUB, E_ADDU, E_JALR, E_MFLO, E_MULT, E_INVALID, E_SLL, E_INVALID, E_MUL, E_CLZ};
    e_wr   = '{5'd0, 5'd0, 5'd0, 5'd31, 5'd8, 5'd0, 5'd0, 5'd10, 5'd0, 5'd10, 5'd10};
    e_inv  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    e_inst = '{E_JR, E_SUB, E_ADDU, E_JALR, E_MFLO, E_MULT, E_INVALID, E_SLL, E_INVALID, E_INVALID, E_INVALID};
    e_wr   = '{5'd0, 5'd0, 5'd0, 5'd31, 5'd8, 5'd0, 5'd0, 5'd10, 5'd0, 5'd0, 5'd0};
    e_inv  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`endif
    for (int i = 0; i < 11; i++) begin
      logic [31:0] w;
      w = codes[i];
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_code = w; bus.in_pc = 32'h1000 + 32'(i * 4);
      step();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_inst !== e_inst[i]) begin errors++; $display("FAIL dec_inst[%0d] %h: got %0d want %0d", i, w, bus.out_inst, e_inst[i]); end
      checks++; if (bus.out_wr_reg !== e_wr[i]) begin errors++; $display("FAIL dec_wr_reg[%0d] %h: got %0d want %0d", i, w, bus.out_wr_reg, e_wr[i]); end
      checks++; if (bus.out_invalid !== e_inv[i]) begin errors++; $display("FAIL dec_invalid[%0d] %h: got %0b want %0b", i, w, bus.out_invalid, e_inv[i]); end
      checks++; if (bus.out_reg_s !== w[25:21] || bus.out_reg_t !== w[20:16] || bus.out_reg_d !== w[15:11] || bus.out_shift !== w[10:6])
        begin errors++; $display("FAIL dec_fields[%0d] %h: got s%0d t%0d d%0d sh%0d", i, w, bus.out_reg_s, bus.out_reg_t, bus.out_reg_d, bus.out_shift); end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_full();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_code = 32'h00000020; bus.in_pc = 32'h200;
    step();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_1: got %0b want 1", bus.in_ready); end
    bus.in_code = 32'h00000021; bus.in_pc = 32'h204;
    step();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_2: got %0b want 0", bus.in_ready); end
    bus.in_code = 32'h00000022; bus.in_pc = 32'h208;
    step();
    checks++; if (bus.in_ready !== 1'b0 || bus.out_pc !== 32'h200)
      begin errors++; $display("FAIL full_hold: ready %0b pc %0h want 0 200", bus.in_ready, bus.out_pc); end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h204 || bus.out_inst !== E_ADDU)
      begin errors++; $display("FAIL full_order: valid %0b pc %0h inst %0d want 1 204 %0d", bus.out_valid, bus.out_pc, bus.out_inst, E_ADDU); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_extra_dropped: got %0b want 0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_code = 32'h00000020; bus.in_pc = 32'h300;
    step();
    for (int i = 1; i <= 10; i++) begin
      bus.in_code = 32'h00000020 | (32'(i) << 11);
      bus.in_pc = 32'h300 + 32'(i * 4);
      step();
      checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1)
        begin errors++; $display("FAIL b2b_count[%0d]: valid %0b ready %0b want 1 1", i, bus.out_valid, bus.in_ready); end
      checks++; if (bus.out_pc !== 32'h300 + 32'(i * 4) || bus.out_reg_d !== 5'(i))
        begin errors++; $display("FAIL b2b_data[%0d]: pc %0h rd %0d want %0h %0d", i, bus.out_pc, bus.out_reg_d, 32'h300 + 32'(i * 4), i); end
    end
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0b want 0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_code = 32'h00000020; bus.in_pc = 32'h400;
    step();
    bus.in_pc = 32'h404;
    step();
    flush = 1'b1; bus.in_pc = 32'h408;
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_full: valid %0b ready %0b want 0 1", bus.out_valid, bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_pc = 32'h40C;
    step();
    flush = 1'b1; bus.in_pc = 32'h410;
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_push_dropped: got %0b want 0", bus.out_valid); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_stays_empty: got %0b want 0", bus.out_valid); end
    bus.in_valid = 1'b1; bus.in_pc = 32'h414;
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h414)
      begin errors++; $display("FAIL flush_recover: valid %0b pc %0h want 1 414", bus.out_valid, bus.out_pc); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_code = 32'h012A4020; bus.in_pc = 32'h500;
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin errors++; $display("FAIL rst_mid_state: valid %0b ready %0b want 0 1", bus.out_valid, bus.in_ready); end
    checks++; if (bus.out_pc !== 32'd0 || bus.out_inst !== 8'd0 || bus.out_reg_s !== 5'd0)
      begin errors++; $display("FAIL rst_mid_cleared: pc %0h inst %0d s %0d want 0", bus.out_pc, bus.out_inst, bus.out_reg_s); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_decode();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
